serial_word_port: RTL and testbench

//  Parametrised bit/lane-serial host port onto the pairing core's operand register file.

---
 rtl/serial_word_port.sv | 93 +++++++++
 tb/tb_serial_word_port.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_port.sv
// Lane-serial host port onto an operand register file: load a word, shift it out/in
// LANES bits per beat, commit it back, with beat counting and error detection.
module serial_word_port #(
    parameter int WIDTH  = 198,
    parameter int LANES  = 1,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int STRICT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic              update,
    input  logic              ready,
    input  logic              w,
    input  logic [LANES-1:0]  i,
    output logic [LANES-1:0]  o,
    output logic              full,
    output logic              err,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    localparam int BEATS = WIDTH / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Host strobes are single-cycle commands sampled on each rising edge while sel
    // is high; there is no backpressure. Precedence: update&&w conflict, bad address,
    // update, w, ready. mem_wr is a registered one-cycle strobe carrying mem_wdata.

    logic [WIDTH-1:0] sh, sh_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             err_d;
    logic             wr_d;
    logic             at_end;
    logic             bad_addr;

    assign at_end   = (cnt == BEATS_C);
    assign bad_addr = (32'(addr) >= DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh     <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            mem_wr <= 1'b0;
        end else begin
            sh     <= sh_d;
            cnt    <= cnt_d;
            err    <= err_d;
            mem_wr <= wr_d;
        end
    end

    always_comb begin
        sh_d  = sh;
        cnt_d = cnt;
        err_d = err;
        wr_d  = 1'b0;
        if (sel) begin
            if (update && w) begin
                err_d = 1'b1;
            end else if (bad_addr && (update || w)) begin
                err_d = 1'b1;
            end else if (update) begin
                sh_d  = mem_rdata;
                cnt_d = '0;
                err_d = 1'b0;
            end else if (w) begin
                // Commit the word as it stands; a same-cycle ready beat is dropped.
                if (at_end || (STRICT == 0)) wr_d = 1'b1;
                else                         err_d = 1'b1;
            end else if (ready) begin
                sh_d = {i, sh[WIDTH-1:LANES]};
                if (at_end) err_d = 1'b1;
                else        cnt_d = cnt + CNT_ONE;
            end
        end
    end

    assign o         = sh[LANES-1:0];
    assign full      = at_end;
    assign mem_en    = sel;
    assign mem_addr  = addr;
    assign mem_wdata = sh;

endmodule

// File: tb/tb_serial_word_port.sv
// Directed bench for serial_word_port: one 1-lane instance (DEPTH 64) and one
// 2-lane instance (DEPTH 40), each backed by a bench-side register file.
module tb_serial_word_port;

    localparam int W = 198;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // 1-lane instance
    logic         a_sel, a_update, a_ready, a_w, a_full, a_err, a_mem_en, a_mem_wr;
    logic [5:0]   a_addr, a_mem_addr;
    logic [0:0]   a_i, a_o;
    logic [W-1:0] a_mem_wdata, a_mem_rdata;
    logic [W-1:0] mem_a [64];

    // 2-lane instance
    logic         b_sel, b_update, b_ready, b_w, b_full, b_err, b_mem_en, b_mem_wr;
    logic [5:0]   b_addr, b_mem_addr;
    logic [1:0]   b_i, b_o;
    logic [W-1:0] b_mem_wdata, b_mem_rdata;
    logic [W-1:0] mem_b [64];

    int checks = 0;
    int errors = 0;
    int wr_a = 0;
    int wr_b = 0;

    localparam logic [W-1:0] P0 = {6'h2d, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 64'hdead_beef_cafe_f00d};
    localparam logic [W-1:0] P1 = {6'h13, 64'h2118_a5a5_0f0f_3c3c, 64'h9669_c3c3_1234_8765, 64'h5a5a_0000_ffff_4598};
    localparam logic [W-1:0] Q0 = {6'h39, 64'h0a90_1111_2222_3333, 64'h4444_5555_6666_7777, 64'h8888_9999_aaaa_bbbb};
    localparam logic [W-1:0] Q1 = {6'h05, 64'h0a90_7e7e_8181_5048, 64'h3141_5926_5358_9793, 64'h2718_2818_2845_5048};

    serial_word_port #(.WIDTH(W), .LANES(1), .ADDR_W(6), .DEPTH(64), .STRICT(1)) dut_a (
        .clk(clk), .reset(reset), .sel(a_sel), .addr(a_addr), .update(a_update),
        .ready(a_ready), .w(a_w), .i(a_i), .o(a_o), .full(a_full), .err(a_err),
        .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_wr(a_mem_wr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    serial_word_port #(.WIDTH(W), .LANES(2), .ADDR_W(6), .DEPTH(40), .STRICT(1)) dut_b (
        .clk(clk), .reset(reset), .sel(b_sel), .addr(b_addr), .update(b_update),
        .ready(b_ready), .w(b_w), .i(b_i), .o(b_o), .full(b_full), .err(b_err),
        .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_wr(b_mem_wr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    assign a_mem_rdata = mem_a[a_mem_addr];
    assign b_mem_rdata = mem_b[b_mem_addr];

    always @(posedge clk) begin
        if (a_mem_wr) begin
            mem_a[a_mem_addr] <= a_mem_wdata;
            wr_a <= wr_a + 1;
        end
        if (b_mem_wr) begin
            mem_b[b_mem_addr] <= b_mem_wdata;
            wr_b <= wr_b + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic update_a(input logic [5:0] ad);
        a_addr = ad; a_update = 1'b1;
        tick();
        a_update = 1'b0;
    endtask

    task automatic update_b(input logic [5:0] ad);
        b_addr = ad; b_update = 1'b1;
        tick();
        b_update = 1'b0;
    endtask

    // Shift n beats of din into dut_a while recording o ahead of each beat.
    task automatic shift_a(input logic [W-1:0] din, input int n, output logic [W-1:0] obs);
        obs = '0;
        for (int k = 0; k < n; k++) begin
            a_i = din[k];
            a_ready = 1'b1;
            if (k < W) obs[k] = a_o[0];
            tick();
        end
        a_ready = 1'b0;
    endtask

    task automatic shift_b(input logic [W-1:0] din, input int n, output logic [W-1:0] obs);
        obs = '0;
        for (int k = 0; k < n; k++) begin
            b_i = din[2*k +: 2];
            b_ready = 1'b1;
            obs[2*k +: 2] = b_o;
            tick();
        end
        b_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++;
        if ({a_o, a_full, a_err, a_mem_wr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_a: got o/full/err/wr=%b expected 0000", {a_o, a_full, a_err, a_mem_wr});
        end
        checks++;
        if ({b_o, b_full, b_err, b_mem_wr} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_b: got o/full/err/wr=%b expected 00000", {b_o, b_full, b_err, b_mem_wr});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_lanes1();
        logic [W-1:0] obs;
        update_a(6'd3);
        shift_a(P1, W, obs);
        checks++;
        if (obs !== P0) begin
            errors++;
            $display("FAIL read_p0_lanes1: got %h expected %h", obs, P0);
        end
        checks++;
        if ({a_full, a_err} !== 2'b10) begin
            errors++;
            $display("FAIL full_before_w: got full/err=%b expected 10", {a_full, a_err});
        end
        a_w = 1'b1;
        tick();
        a_w = 1'b0;
        checks++;
        if (a_mem_wr !== 1'b1 || a_mem_wdata !== P1 || a_mem_addr !== 6'd3) begin
            errors++;
            $display("FAIL write_strobe: got wr=%b addr=%0d data=%h expected wr=1 addr=3 data=%h",
                     a_mem_wr, a_mem_addr, a_mem_wdata, P1);
        end
        tick();
        checks++;
        if (a_mem_wr !== 1'b0 || wr_a != 1 || mem_a[3] !== P1 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL write_commit: got wr=%b writes=%0d err=%b mem=%h expected wr=0 writes=1 err=0 mem=%h",
                     a_mem_wr, wr_a, a_err, mem_a[3], P1);
        end
    endtask

    task automatic test_readback();
        logic [W-1:0] obs;
        update_a(6'd3);
        checks++;
        if (a_o !== P1[0:0] || a_full !== 1'b0) begin
            errors++;
            $display("FAIL readback_first: got o=%b full=%b expected o=%b full=0", a_o, a_full, P1[0]);
        end
        shift_a('0, W - 1, obs);
        checks++;
        if (a_full !== 1'b0) begin
            errors++;
            $display("FAIL full_at_197: got %b expected 0", a_full);
        end
        a_i = 1'b0; a_ready = 1'b1;
        obs[W-1] = a_o[0];
        tick();
        a_ready = 1'b0;
        checks++;
        if (obs !== P1 || a_full !== 1'b1) begin
            errors++;
            $display("FAIL readback_stream: got %h full=%b expected %h full=1", obs, a_full, P1);
        end
    endtask

    task automatic test_short_write();
        logic [W-1:0] obs;
        int wr0;
        mem_a[5] = P0;
        update_a(6'd5);
        shift_a(P1, W - 1, obs);
        wr0 = wr_a;
        a_w = 1'b1;
        tick();
        a_w = 1'b0;
        checks++;
        if (a_mem_wr !== 1'b0 || a_err !== 1'b1) begin
            errors++;
            $display("FAIL short_write: got wr=%b err=%b expected wr=0 err=1", a_mem_wr, a_err);
        end
        tick();
        checks++;
        if (wr_a != wr0 || mem_a[5] !== P0) begin
            errors++;
            $display("FAIL short_write_mem: got writes=%0d mem=%h expected writes=%0d mem=%h", wr_a, mem_a[5], wr0, P0);
        end
        update_a(6'd5);
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", a_err);
        end
    endtask

    task automatic test_over_shift();
        logic [W-1:0] obs;
        update_a(6'd3);
        shift_a(P0, W, obs);
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("FAIL over_shift_pre: got err=%b expected 0", a_err);
        end
        shift_a(P0, 1, obs);
        checks++;
        if (a_err !== 1'b1 || a_full !== 1'b1 || a_o !== P0[1:1]) begin
            errors++;
            $display("FAIL over_shift: got err=%b full=%b o=%b expected err=1 full=1 o=%b",
                     a_err, a_full, a_o, P0[1]);
        end
    endtask

    task automatic test_lanes2();
        logic [W-1:0] obs;
        int wr0;
        update_b(6'd7);
        shift_b(Q1, W / 2, obs);
        checks++;
        if (obs !== Q0 || b_full !== 1'b1) begin
            errors++;
            $display("FAIL lanes2_read_q0: got %h full=%b expected %h full=1", obs, b_full, Q0);
        end
        b_w = 1'b1;
        tick();
        b_w = 1'b0;
        checks++;
        if (b_mem_wr !== 1'b1 || b_mem_wdata !== Q1) begin
            errors++;
            $display("FAIL lanes2_write: got wr=%b data=%h expected wr=1 data=%h", b_mem_wr, b_mem_wdata, Q1);
        end
        tick();
        update_b(6'd7);
        shift_b('0, W / 2, obs);
        checks++;
        if (obs !== Q1 || mem_b[7] !== Q1) begin
            errors++;
            $display("FAIL lanes2_roundtrip: got %h mem=%h expected %h", obs, mem_b[7], Q1);
        end
        wr0 = wr_b;
        b_update = 1'b1; b_w = 1'b1;
        tick();
        b_update = 1'b0; b_w = 1'b0;
        tick();
        checks++;
        if (b_err !== 1'b1 || wr_b != wr0 || b_full !== 1'b1) begin
            errors++;
            $display("FAIL update_and_w: got err=%b writes=%0d full=%b expected err=1 writes=%0d full=1",
                     b_err, wr_b, b_full, wr0);
        end
    endtask

    task automatic test_range();
        int wr0;
        update_b(6'd7);
        update_b(6'd40);
        checks++;
        if (b_err !== 1'b1 || b_o !== Q1[1:0]) begin
            errors++;
            $display("FAIL range_update: got err=%b o=%b expected err=1 o=%b", b_err, b_o, Q1[1:0]);
        end
        update_b(6'd7);
        wr0 = wr_b;
        b_addr = 6'd63; b_w = 1'b1;
        tick();
        b_w = 1'b0;
        tick();
        checks++;
        if (b_err !== 1'b1 || wr_b != wr0) begin
            errors++;
            $display("FAIL range_write: got err=%b writes=%0d expected err=1 writes=%0d", b_err, wr_b, wr0);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] obs;
        int wr0;
        update_a(6'd3);
        shift_a(P0, 50, obs);
        wr0 = wr_a;
        reset = 1'b0;
        #1;
        checks++;
        if (a_o !== 1'b0 || a_full !== 1'b0 || a_err !== 1'b0 || a_mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got o=%b full=%b err=%b wr=%b expected all 0", a_o, a_full, a_err, a_mem_wr);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        shift_a('0, W - 1, obs);
        checks++;
        if (obs !== '0 || a_full !== 1'b0 || wr_a != wr0) begin
            errors++;
            $display("FAIL reset_discard: got sh=%h full=%b writes=%0d expected sh=0 full=0 writes=%0d",
                     obs, a_full, wr_a, wr0);
        end
    endtask

    task automatic test_sel_idle();
        logic [W-1:0] obs;
        int wr0;
        update_a(6'd3);
        wr0 = wr_a;
        a_sel = 1'b0;
        for (int j = 0; j < 20; j++) begin
            a_ready  = j[0];
            a_i      = 1'($urandom_range(0, 1));
            a_update = (j % 5 == 0);
            a_w      = (j % 7 == 3);
            tick();
        end
        a_ready = 1'b0; a_update = 1'b0; a_w = 1'b0;
        checks++;
        if (a_o !== P1[0:0] || a_full !== 1'b0 || wr_a != wr0 || a_mem_en !== 1'b0) begin
            errors++;
            $display("FAIL sel_idle: got o=%b full=%b writes=%0d en=%b expected o=%b full=0 writes=%0d en=0",
                     a_o, a_full, wr_a, a_mem_en, P1[0], wr0);
        end
        a_sel = 1'b1;
        shift_a('0, W, obs);
        checks++;
        if (obs !== P1 || a_full !== 1'b1) begin
            errors++;
            $display("FAIL sel_idle_hold: got %h full=%b expected %h full=1", obs, a_full, P1);
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem_a[k] = '0;
            mem_b[k] = '0;
        end
        mem_a[3] = P0;
        mem_b[7] = Q0;
        a_sel = 1'b1; a_addr = '0; a_update = 1'b0; a_ready = 1'b0; a_w = 1'b0; a_i = '0;
        b_sel = 1'b1; b_addr = '0; b_update = 1'b0; b_ready = 1'b0; b_w = 1'b0; b_i = '0;

        test_reset();
        test_write_lanes1();
        test_readback();
        test_short_write();
        test_over_shift();
        test_lanes2();
        test_range();
        test_reset_mid_shift();
        test_sel_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
